// File: rtl/mdio_mgmt_arbiter.sv
// Arbitrates one MDIO serial engine between two host requesters and a periodic
// link-status poller; builds Clause-22 command words and guards against a hung engine.
module mdio_mgmt_arbiter #(
  parameter int          POLL_CYCLES    = 1000000,
  parameter logic [4:0]  POLL_PHYAD     = 5'd0,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [1:0]  i_req_valid,
  input  logic [1:0]  i_req_write,
  input  logic [9:0]  i_req_phyad,
  input  logic [9:0]  i_req_regad,
  input  logic [31:0] i_req_wdata,
  output logic [1:0]  o_req_ready,
  output logic [1:0]  o_rsp_valid,
  output logic [15:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_link_up,
  output logic        o_mdio_new_cmd,
  output logic [31:0] o_mdio_cmd,
  output logic        o_mdio_reset,
  input  logic        i_mdio_rdy,
  input  logic        i_mdio_wr_done,
  input  logic        i_mdio_rd_done,
  input  logic [15:0] i_mdio_rdata
);

  localparam int PT_W  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [PT_W-1:0]  POLL_LAST = PT_W'((POLL_CYCLES > 0) ? POLL_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [PT_W-1:0]   poll_tmr_q, poll_tmr_d;
  logic              poll_pend_q, poll_pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              own_poll_q, own_poll_d;
  logic              own_idx_q, own_idx_d;
  logic [1:0]        req_ready_q, req_ready_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [15:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              link_up_q, link_up_d;
  logic              new_cmd_q, new_cmd_d;
  logic [31:0]       cmd_q, cmd_d;
  logic              mdio_reset_q, mdio_reset_d;

  logic              gnt_idx;
  logic              done;
  logic              fin_err;
  logic [15:0]       fin_data;
  logic              unused_rdy;

  // Engine ready carries no completion meaning here; only rd/wr done finish a transaction.
  assign unused_rdy = i_mdio_rdy;

  function automatic logic [31:0] build_cmd(input logic wr, input logic [4:0] phyad,
                                            input logic [4:0] regad, input logic [15:0] wdata);
    logic [31:0] c;
    c     = '0;
    c[1]  = 1'b1;
    c[2]  = ~wr;
    c[3]  = wr;
    c[14] = wr;
    for (int i = 0; i < 5; i++) begin
      c[4+i] = phyad[4-i];
      c[9+i] = regad[4-i];
    end
    for (int i = 0; i < 16; i++) c[16+i] = wr & wdata[15-i];
    return c;
  endfunction

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    poll_tmr_d   = poll_tmr_q;
    poll_pend_d  = poll_pend_q;
    cnt_d        = cnt_q;
    own_poll_d   = own_poll_q;
    own_idx_d    = own_idx_q;
    req_ready_d  = 2'b00;
    rsp_valid_d  = 2'b00;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    link_up_d    = link_up_q;
    new_cmd_d    = 1'b0;
    cmd_d        = cmd_q;
    mdio_reset_d = 1'b0;
    gnt_idx      = i_req_valid[ptr_q] ? ptr_q : ~ptr_q;
    done         = i_mdio_rd_done | i_mdio_wr_done;
    fin_err      = 1'b0;
    fin_data     = 16'h0000;

    // A wrap while a poll is still pending is dropped rather than queued.
    if (POLL_CYCLES != 0) begin
      if (poll_tmr_q == POLL_LAST) begin
        poll_tmr_d = '0;
        if (!poll_pend_q) poll_pend_d = 1'b1;
      end else begin
        poll_tmr_d = poll_tmr_q + PT_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (poll_pend_q) begin
          poll_pend_d = 1'b0;
          own_poll_d  = 1'b1;
          cmd_d       = build_cmd(1'b0, POLL_PHYAD, 5'd1, 16'h0000);
          state_d     = ISSUE;
        end else if (|i_req_valid) begin
          own_poll_d           = 1'b0;
          own_idx_d            = gnt_idx;
          req_ready_d[gnt_idx] = 1'b1;
          ptr_d                = ~gnt_idx;
          cmd_d = build_cmd(i_req_write[gnt_idx],
                            gnt_idx ? i_req_phyad[9:5]   : i_req_phyad[4:0],
                            gnt_idx ? i_req_regad[9:5]   : i_req_regad[4:0],
                            gnt_idx ? i_req_wdata[31:16] : i_req_wdata[15:0]);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        new_cmd_d = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // A done pulse on the final count still counts as success.
        if (done || cnt_q == TO_LAST) begin
          fin_err      = ~done;
          fin_data     = i_mdio_rd_done ? i_mdio_rdata : 16'h0000;
          mdio_reset_d = ~done;
          state_d      = RESP;
          if (own_poll_q) begin
            link_up_d = ~fin_err & fin_data[2];
          end else begin
            rsp_valid_d[own_idx_q] = 1'b1;
            rsp_rdata_d            = fin_data;
            rsp_err_d              = fin_err;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      poll_tmr_q   <= '0;
      poll_pend_q  <= 1'b0;
      cnt_q        <= '0;
      own_poll_q   <= 1'b0;
      own_idx_q    <= 1'b0;
      req_ready_q  <= 2'b00;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= 16'h0000;
      rsp_err_q    <= 1'b0;
      link_up_q    <= 1'b0;
      new_cmd_q    <= 1'b0;
      cmd_q        <= 32'h0;
      mdio_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      poll_tmr_q   <= poll_tmr_d;
      poll_pend_q  <= poll_pend_d;
      cnt_q        <= cnt_d;
      own_poll_q   <= own_poll_d;
      own_idx_q    <= own_idx_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      link_up_q    <= link_up_d;
      new_cmd_q    <= new_cmd_d;
      cmd_q        <= cmd_d;
      mdio_reset_q <= mdio_reset_d;
    end
  end

  assign o_req_ready    = req_ready_q;
  assign o_rsp_valid    = rsp_valid_q;
  assign o_rsp_rdata    = rsp_rdata_q;
  assign o_rsp_err      = rsp_err_q;
  assign o_link_up      = link_up_q;
  assign o_mdio_new_cmd = new_cmd_q;
  assign o_mdio_cmd     = cmd_q;
  assign o_mdio_reset   = mdio_reset_q;

endmodule

// File: tb/tb_mdio_mgmt_arbiter.sv
// Directed bench for mdio_mgmt_arbiter: one instance without polling for host traffic,
// one with a 100-cycle poller driven by a small automatic engine model.
module tb_mdio_mgmt_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Host-side instance (polling disabled)
  logic        rst_n;
  logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [9:0]  req_phyad, req_regad;
  logic [31:0] req_wdata, mdio_cmd;
  logic [15:0] rsp_rdata, mdio_rdata;
  logic        rsp_err, link_up, mdio_new_cmd, mdio_reset, mdio_rdy, wr_done, rd_done;

  mdio_mgmt_arbiter #(.POLL_CYCLES(0), .POLL_PHYAD(5'd0), .TIMEOUT_CYCLES(64)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_valid(req_valid), .i_req_write(req_write), .i_req_phyad(req_phyad),
    .i_req_regad(req_regad), .i_req_wdata(req_wdata),
    .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
    .o_rsp_err(rsp_err), .o_link_up(link_up), .o_mdio_new_cmd(mdio_new_cmd),
    .o_mdio_cmd(mdio_cmd), .o_mdio_reset(mdio_reset), .i_mdio_rdy(mdio_rdy),
    .i_mdio_wr_done(wr_done), .i_mdio_rd_done(rd_done), .i_mdio_rdata(mdio_rdata));

  // Poller instance
  logic        p_reset_n;
  logic [1:0]  p_req_valid, p_req_write, p_req_ready, p_rsp_valid;
  logic [9:0]  p_req_phyad, p_req_regad;
  logic [31:0] p_req_wdata, p_mdio_cmd;
  logic [15:0] p_rsp_rdata, p_mdio_rdata, p_resp;
  logic        p_rsp_err, p_link_up, p_new_cmd, p_mdio_reset, p_mdio_rdy, p_wr_done, p_rd_done;

  mdio_mgmt_arbiter #(.POLL_CYCLES(100), .POLL_PHYAD(5'd2), .TIMEOUT_CYCLES(64)) dut_p (
    .i_clk(clk), .i_reset_n(p_reset_n),
    .i_req_valid(p_req_valid), .i_req_write(p_req_write), .i_req_phyad(p_req_phyad),
    .i_req_regad(p_req_regad), .i_req_wdata(p_req_wdata),
    .o_req_ready(p_req_ready), .o_rsp_valid(p_rsp_valid), .o_rsp_rdata(p_rsp_rdata),
    .o_rsp_err(p_rsp_err), .o_link_up(p_link_up), .o_mdio_new_cmd(p_new_cmd),
    .o_mdio_cmd(p_mdio_cmd), .o_mdio_reset(p_mdio_reset), .i_mdio_rdy(p_mdio_rdy),
    .i_mdio_wr_done(p_wr_done), .i_mdio_rd_done(p_rd_done), .i_mdio_rdata(p_mdio_rdata));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one request from requester r for a single cycle, then reports the accept
  // pulse and the first WAIT-cycle strobe/command.
  task automatic issue(input int r, input logic wr, input logic [4:0] phy, input logic [4:0] regad,
                       input logic [15:0] wd, output logic [1:0] rdy, output logic nc,
                       output logic [31:0] cmd);
    req_write[r]          = wr;
    req_phyad[5*r +: 5]   = phy;
    req_regad[5*r +: 5]   = regad;
    req_wdata[16*r +: 16] = wd;
    req_valid[r]          = 1'b1;
    tick();
    rdy          = req_ready;
    req_valid[r] = 1'b0;
    tick();
    nc  = mdio_new_cmd;
    cmd = mdio_cmd;
  endtask

  // Engine model for the poller instance: answers every command three cycles later.
  initial begin
    p_rd_done = 1'b0; p_wr_done = 1'b0; p_mdio_rdy = 1'b0; p_mdio_rdata = 16'h0;
    forever begin
      tick();
      if (p_new_cmd === 1'b1) begin
        tick();
        tick();
        p_rd_done = 1'b1; p_mdio_rdata = p_resp;
        tick();
        p_rd_done = 1'b0; p_mdio_rdata = 16'h0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    logic [54:0] z = '0;
    rst_n = 1'b0; p_reset_n = 1'b0;
    req_valid = '0; req_write = '0; req_phyad = '0; req_regad = '0; req_wdata = '0;
    p_req_valid = '0; p_req_write = '0; p_req_phyad = '0; p_req_regad = '0; p_req_wdata = '0;
    mdio_rdata = '0; mdio_rdy = 1'b0; wr_done = 1'b0; rd_done = 1'b0; p_resp = 16'h0;
    tick(); tick();
    n_cmp++; if ({req_ready, rsp_valid, rsp_rdata, rsp_err, link_up, mdio_new_cmd, mdio_cmd, mdio_reset} !== z) begin
      n_bad++; $display("FAIL reset_outs: got %h want 0", {req_ready, rsp_valid, rsp_rdata, rsp_err, link_up, mdio_new_cmd, mdio_cmd, mdio_reset}); end
    n_cmp++; if ({p_req_ready, p_rsp_valid, p_rsp_rdata, p_rsp_err, p_link_up, p_new_cmd, p_mdio_cmd, p_mdio_reset} !== z) begin
      n_bad++; $display("FAIL reset_outs_poll: got %h want 0", {p_req_ready, p_rsp_valid, p_rsp_rdata, p_rsp_err, p_link_up, p_new_cmd, p_mdio_cmd, p_mdio_reset}); end
    rst_n = 1'b1;
    tick(); tick();
    n_cmp++; if ({req_ready, mdio_new_cmd} !== 3'b000) begin
      n_bad++; $display("FAIL idle_after_reset: got %b want 000", {req_ready, mdio_new_cmd}); end
  endtask

  task automatic test_read;
    logic [1:0] rdy; logic nc; logic [31:0] cmd;
    issue(0, 1'b0, 5'd1, 5'd2, 16'h0, rdy, nc, cmd);
    n_cmp++; if (rdy !== 2'b01) begin n_bad++; $display("FAIL rd_ready: got %b want 01", rdy); end
    n_cmp++; if (nc !== 1'b1) begin n_bad++; $display("FAIL rd_new_cmd: got %b want 1", nc); end
    n_cmp++; if (cmd !== 32'h0000_1106) begin n_bad++; $display("FAIL rd_cmd: got %h want 00001106", cmd); end
    repeat (3) tick();
    rd_done = 1'b1; mdio_rdata = 16'h1234;
    tick();
    rd_done = 1'b0; mdio_rdata = 16'h0;
    n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b0, 16'h1234}) begin
      n_bad++; $display("FAIL rd_rsp: got v=%b e=%b d=%h want v=01 e=0 d=1234", rsp_valid, rsp_err, rsp_rdata); end
    tick();
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rd_rsp_pulse: got %b want 00", rsp_valid); end
  endtask

  task automatic test_write;
    logic [1:0] rdy; logic nc; logic [31:0] cmd;
    mdio_rdata = 16'hFFFF;
    issue(1, 1'b1, 5'd3, 5'd0, 16'h8000, rdy, nc, cmd);
    n_cmp++; if (rdy !== 2'b10) begin n_bad++; $display("FAIL wr_ready: got %b want 10", rdy); end
    n_cmp++; if (cmd !== 32'h0001_418A) begin n_bad++; $display("FAIL wr_cmd: got %h want 0001418a", cmd); end
    tick(); tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b0, 16'h0000}) begin
      n_bad++; $display("FAIL wr_rsp: got v=%b e=%b d=%h want v=10 e=0 d=0000", rsp_valid, rsp_err, rsp_rdata); end
    mdio_rdata = 16'h0;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_cmd [2] = '{32'hA500_684A, 32'h005A_78CA};
    logic [31:0] cmd0;
    int n;
    req_write = 2'b11;
    req_phyad = {5'd6, 5'd4}; req_regad = {5'd7, 5'd5}; req_wdata = {16'h5A00, 16'h00A5};
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (req_ready === 2'b00 && n < 20) begin tick(); n++; end
      n_cmp++; if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_bad++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, (i % 2 == 0) ? 2'b01 : 2'b10); end
      if (i == 3) req_valid = 2'b00;
      tick();
      cmd0 = mdio_cmd;
      n_cmp++; if (cmd0 !== exp_cmd[i % 2]) begin n_bad++; $display("FAIL rr_cmd%0d: got %h want %h", i, cmd0, exp_cmd[i % 2]); end
      for (int k = 0; k < 3; k++) begin
        tick();
        n_cmp++; if (mdio_cmd !== cmd0) begin n_bad++; $display("FAIL rr_hold%0d: got %h want %h", i, mdio_cmd, cmd0); end
      end
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      n_cmp++; if (rsp_valid !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_bad++; $display("FAIL rr_rsp%0d: got %b want %b", i, rsp_valid, (i % 2 == 0) ? 2'b01 : 2'b10); end
    end
    tick();
  endtask

  task automatic test_rdy_and_stray_done;
    logic [1:0] rdy; logic nc; logic [31:0] cmd;
    rd_done = 1'b1; mdio_rdata = 16'h0001;
    tick();
    rd_done = 1'b0; mdio_rdata = 16'h0;
    tick();
    n_cmp++; if ({rsp_valid, req_ready, mdio_new_cmd} !== 5'b0) begin
      n_bad++; $display("FAIL stray_done: got %b want 00000", {rsp_valid, req_ready, mdio_new_cmd}); end
    issue(0, 1'b1, 5'd1, 5'd1, 16'h0001, rdy, nc, cmd);
    tick();
    mdio_rdy = 1'b1;
    tick();
    mdio_rdy = 1'b0;
    tick();
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rdy_only: got %b want 00", rsp_valid); end
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL rdy_then_done: got %b want 01", rsp_valid); end
    tick();
  endtask

  task automatic test_timeout;
    logic [1:0] rdy; logic nc; logic [31:0] cmd;
    issue(0, 1'b0, 5'd7, 5'd1, 16'h0, rdy, nc, cmd);
    n_cmp++; if (nc !== 1'b1) begin n_bad++; $display("FAIL to_new_cmd: got %b want 1", nc); end
    repeat (63) tick();
    n_cmp++; if ({mdio_reset, rsp_valid} !== 3'b000) begin
      n_bad++; $display("FAIL to_early: got %b want 000", {mdio_reset, rsp_valid}); end
    tick();
    n_cmp++; if ({mdio_reset, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 2'b01, 1'b1, 16'h0}) begin
      n_bad++; $display("FAIL to_abort: got r=%b v=%b e=%b d=%h want r=1 v=01 e=1 d=0000", mdio_reset, rsp_valid, rsp_err, rsp_rdata); end
    tick();
    n_cmp++; if (mdio_reset !== 1'b0) begin n_bad++; $display("FAIL to_reset_pulse: got %b want 0", mdio_reset); end
    issue(1, 1'b0, 5'd2, 5'd3, 16'h0, rdy, nc, cmd);
    n_cmp++; if (rdy !== 2'b10) begin n_bad++; $display("FAIL to_next_ready: got %b want 10", rdy); end
    tick();
    rd_done = 1'b1; mdio_rdata = 16'hBEEF;
    tick();
    rd_done = 1'b0; mdio_rdata = 16'h0;
    n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b0, 16'hBEEF}) begin
      n_bad++; $display("FAIL to_next_rsp: got v=%b e=%b d=%h want v=10 e=0 d=beef", rsp_valid, rsp_err, rsp_rdata); end
    tick();
  endtask

  task automatic test_done_vs_timeout;
    logic [1:0] rdy; logic nc; logic [31:0] cmd;
    issue(0, 1'b0, 5'd1, 5'd1, 16'h0, rdy, nc, cmd);
    repeat (63) tick();
    rd_done = 1'b1; mdio_rdata = 16'h00C3;
    tick();
    rd_done = 1'b0; mdio_rdata = 16'h0;
    n_cmp++; if ({mdio_reset, rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 2'b01, 1'b0, 16'h00C3}) begin
      n_bad++; $display("FAIL done_vs_to: got r=%b v=%b e=%b d=%h want r=0 v=01 e=0 d=00c3", mdio_reset, rsp_valid, rsp_err, rsp_rdata); end
    tick();
  endtask

  task automatic test_reset_in_wait;
    logic [1:0] rdy; logic nc; logic [31:0] cmd;
    int seen;
    issue(1, 1'b1, 5'd5, 5'd5, 16'hFFFF, rdy, nc, cmd);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({req_ready, rsp_valid, rsp_rdata, rsp_err, link_up, mdio_new_cmd, mdio_cmd, mdio_reset} !== 55'h0) begin
      n_bad++; $display("FAIL rst_wait_outs: got cmd=%h v=%b want all 0", mdio_cmd, rsp_valid); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    wr_done = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      wr_done = 1'b0;
      if (rsp_valid !== 2'b00) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_wait_no_rsp: got %0d responses want 0", seen); end
  endtask

  task automatic test_poll;
    int n;
    p_resp = 16'h0004;
    p_reset_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (p_new_cmd !== 1'b1 && n < 200);
    n_cmp++; if (n !== 102) begin n_bad++; $display("FAIL poll1_time: got %0d want 102", n); end
    n_cmp++; if (p_mdio_cmd !== 32'h0000_2086) begin n_bad++; $display("FAIL poll_cmd: got %h want 00002086", p_mdio_cmd); end
    repeat (3) tick();
    n_cmp++; if ({p_link_up, p_rsp_valid} !== 3'b100) begin
      n_bad++; $display("FAIL poll1_link: got %b want 100", {p_link_up, p_rsp_valid}); end
    p_resp = 16'h0000;
    n = 0;
    do begin tick(); n++; end while (p_new_cmd !== 1'b1 && n < 200);
    n_cmp++; if (n !== 97) begin n_bad++; $display("FAIL poll2_time: got %0d want 97", n); end
    repeat (3) tick();
    n_cmp++; if (p_link_up !== 1'b0) begin n_bad++; $display("FAIL poll2_link: got %b want 0", p_link_up); end
  endtask

  task automatic test_three_way;
    int n;
    repeat (95) tick();
    p_req_phyad = {5'd3, 5'd1}; p_req_regad = {5'd4, 5'd2}; p_req_write = 2'b00;
    p_req_valid = 2'b11;
    tick();
    n_cmp++; if (p_req_ready !== 2'b00) begin n_bad++; $display("FAIL prio_poll_first: got %b want 00", p_req_ready); end
    tick();
    n_cmp++; if ({p_new_cmd, p_mdio_cmd} !== {1'b1, 32'h0000_2086}) begin
      n_bad++; $display("FAIL prio_poll_cmd: got nc=%b cmd=%h want nc=1 cmd=00002086", p_new_cmd, p_mdio_cmd); end
    n = 0;
    while (p_req_ready === 2'b00 && n < 40) begin tick(); n++; end
    n_cmp++; if (p_req_ready !== 2'b01) begin n_bad++; $display("FAIL prio_second: got %b want 01", p_req_ready); end
    p_req_valid = 2'b10;
    n = 0;
    do begin tick(); n++; end while (p_req_ready === 2'b00 && n < 40);
    n_cmp++; if (p_req_ready !== 2'b10) begin n_bad++; $display("FAIL prio_third: got %b want 10", p_req_ready); end
    p_req_valid = 2'b00;
    repeat (8) tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_rdy_and_stray_done();
    test_timeout();
    test_done_vs_timeout();
    test_reset_in_wait();
    test_poll();
    test_three_way();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
